ft60x_slv_fifo_emu: RTL
=======================

# ft60x_slv_fifo_emu

Synthesizable emulation of the FT60x slave side of the 245-mode synchronous FIFO bus, i.e. the end that answers `mst_fifo_fsm`-style masters. It accepts master writes into an internal loopback buffer and returns buffered words on master reads, driving TXE_N/RXF_N flow control. It is used for FPGA-to-FPGA bring-up and closed-loop regression of the master controller without an FT60x device on the board.

## Interface
Parameters:
- WIDTH_DATA, 32, data bus width
- CNT_BE, 4, byte-enable width
- DEPTH_LOG2, 9, log2 of loopback buffer depth in words (DEPTH = 2**DEPTH_LOG2)

Ports:
- clk  in  1  bus clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_n  in  1  master write strobe, active-low
- rd_n  in  1  master read strobe, active-low
- oe_n  in  1  master bus-turnaround request, active-low
- data_i  in  WIDTH_DATA  write data from master
- be_i  in  CNT_BE  write byte enables from master
- data_o  out  WIDTH_DATA  read data to master (head of buffer)
- be_o  out  CNT_BE  read byte enables to master
- data_oe  out  1  active-high pad drive enable for data_o/be_o
- txe_n  out  1  low = buffer can accept a write
- rxf_n  out  1  low = buffer holds readable data
- level  out  DEPTH_LOG2+1  current word count
- bus_err  out  1  sticky protocol-violation flag
- stren  in  1  streaming pattern select (used only with FT60X_EMU_PATTERN_EN)

## Operation
- Buffer: first-word-fall-through FIFO, DEPTH entries of {be, data} (WIDTH_DATA+CNT_BE bits); data_o/be_o always show head word, zero when empty.
- Push: at an edge where wr_n=0, txe_n=0 and oe_n=1, store {be_i, data_i}. wr_n=0 while txe_n=1 is silently dropped (normal master overrun, no error).
- Pop: at an edge where rd_n=0, oe_n=0, data_oe=1 and level>0, advance head. rd_n=0 with level=0 is ignored; bus_err set only if rxf_n was 0 at that edge.
- Simultaneous push and pop impossible (push needs oe_n=1); both strobes low with oe_n=0 is a read cycle.
- bus_err also set when wr_n=0 and oe_n=0 at the same edge (contention). Cleared only by rst_n.
- Flags registered from next-state count: txe_n_next = (level_next == DEPTH); rxf_n_next = (level_next == 0).
- Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
- Turnaround FSM, states IDLE, DRIVE: IDLE->DRIVE when oe_n sampled 0; DRIVE->IDLE when oe_n sampled 1. data_oe=1 only in DRIVE.

## Timing
- Reset values: data_o=0, be_o=0, data_oe=0, txe_n=0, rxf_n=1, level=0, bus_err=0, FSM=IDLE, pointers=0.
- Reset mid-transfer discards buffer contents immediately.
- data_oe rises 1 cycle after oe_n sampled low, falls 1 cycle after oe_n sampled high.
- Write-to-read latency: word pushed at edge k -> rxf_n=0 and on data_o after edge k.
- After pop at edge k, next word on data_o after edge k; back-to-back pops each cycle supported.
- Last word popped at edge k -> rxf_n=1 after edge k; master read at k+1 ignored without error.
- Last slot filled at edge k -> txe_n=1 after edge k; write at k+1 dropped.

## Configuration
- FT60X_EMU_PATTERN_EN defined: when stren=1, reads bypass the buffer; data_o = 32-bit counter (reset 0, +1 per pop-qualified read), be_o = all ones, rxf_n held 0; writes still fill the buffer. stren=0 behaves as loopback.
- Not defined: stren ignored, no counter logic, loopback only.

## Test plan
- Reset, write 3 words 0x11,0x22,0x33 be=F, then oe_n=0, rd_n=0 from next cycle -> data_oe=1 one cycle later, reads return 0x11,0x22,0x33 consecutively, rxf_n=1 after third pop, bus_err=0.
- Fill DEPTH words then hold wr_n=0 two more cycles -> txe_n=1 after DEPTH-th push, level=DEPTH, extra words dropped, readback equals first DEPTH words.
- Pointer wrap: push/pop 3*DEPTH+5 words in bursts of 7 -> all data returned in order, level=0 at end.
- wr_n=0 and oe_n=0 same cycle -> bus_err=1 next cycle, stays 1 until rst_n pulse.
- Assert rst_n=0 with level=10 during read burst -> data_oe=0, rxf_n=1, level=0 immediately.
- With FT60X_EMU_PATTERN_EN, stren=1, 4 reads -> data_o 0,1,2,3, be_o=F, rxf_n stays 0.

Source files
------------

// File: rtl/ft60x_slv_fifo_emu.sv
`default_nettype none
// ============================================================================
// Module   : ft60x_slv_fifo_emu
// Purpose  : Emulates the FT60x slave end of the 245-mode synchronous FIFO
//            bus. Master writes land in a first-word-fall-through loopback
//            buffer and master reads return the buffered words, with TXE_N and
//            RXF_N flow control. Intended for FPGA-to-FPGA bring-up and
//            closed-loop regression of a master controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   FT60X_EMU_PATTERN_EN - when defined, stren=1 makes reads return a 32-bit
//                          incrementing counter instead of buffer contents.
//                          When undefined, stren is ignored (loopback only).
// ----------------------------------------------------------------------------
// Ports:
//   clk      in   bus clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_n     in   master write strobe (active low)
//   rd_n     in   master read strobe (active low)
//   oe_n     in   master bus-turnaround request (active low)
//   data_i   in   write data from master
//   be_i     in   write byte enables from master
//   data_o   out  head-of-buffer data to master (zero when empty)
//   be_o     out  head-of-buffer byte enables to master (zero when empty)
//   data_oe  out  pad drive enable for data_o/be_o (active high)
//   txe_n    out  low = buffer can accept a write
//   rxf_n    out  low = buffer holds readable data
//   level    out  current word count
//   bus_err  out  sticky protocol-violation flag
//   stren    in   streaming pattern select (pattern build only)
// ============================================================================
module ft60x_slv_fifo_emu #(
  parameter int WIDTH_DATA = 32,
  parameter int CNT_BE     = 4,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_n,
  input  logic                  rd_n,
  input  logic                  oe_n,
  input  logic [WIDTH_DATA-1:0] data_i,
  input  logic [CNT_BE-1:0]     be_i,
  output logic [WIDTH_DATA-1:0] data_o,
  output logic [CNT_BE-1:0]     be_o,
  output logic                  data_oe,
  output logic                  txe_n,
  output logic                  rxf_n,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  bus_err,
  input  logic                  stren
);

  localparam int                  DEPTH      = 2**DEPTH_LOG2;
  localparam int                  WORD_W     = WIDTH_DATA + CNT_BE;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Turnaround FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]            state_q, state_d;

  logic [WORD_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  txe_n_q, rxf_n_q;
  logic                  bus_err_q, bus_err_d;

  logic                  rd_cycle;
  logic                  push;
  logic                  pop;
  logic                  contention;
  logic                  underrun;
  logic [WORD_W-1:0]     head_word;

  // --------------------------------------------------------------------------
  // Pattern generator (optional)
  // --------------------------------------------------------------------------
`ifdef FT60X_EMU_PATTERN_EN
  logic        pat_mode;
  logic [31:0] pat_cnt_q, pat_cnt_d;

  assign pat_mode = stren;

  always_comb begin
    pat_cnt_d = pat_cnt_q;
    if (pat_mode && rd_cycle) begin
      pat_cnt_d = pat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_cnt_q <= 32'd0;
    end else begin
      pat_cnt_q <= pat_cnt_d;
    end
  end
`else
  logic pat_mode;
  logic unused_stren;

  assign pat_mode     = 1'b0;
  assign unused_stren = stren;
`endif

  // --------------------------------------------------------------------------
  // Turnaround FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!oe_n) state_d = ST_DRIVE;
      ST_DRIVE: if (oe_n)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_oe = (state_q == ST_DRIVE);
  end

  // --------------------------------------------------------------------------
  // Transfer qualification
  // --------------------------------------------------------------------------
  // A read cycle needs the master to own the turnaround and us to be driving.
  assign rd_cycle   = !rd_n && !oe_n && data_oe;
  // txe_n_q always mirrors a full buffer, so it doubles as the overrun guard.
  assign push       = !wr_n && oe_n && !txe_n_q;
  assign pop        = rd_cycle && !pat_mode && (level_q != '0);
  assign contention = !wr_n && !oe_n;
  // Reading an empty buffer is only a violation if we advertised data.
  assign underrun   = !rd_n && !pat_mode && (level_q == '0) && !rxf_n_q;

  // --------------------------------------------------------------------------
  // Buffer bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    bus_err_d = bus_err_q | contention | underrun;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      level_d  = level_q + LEVEL_ONE;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      level_d  = level_q - LEVEL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      txe_n_q   <= 1'b0;
      rxf_n_q   <= 1'b1;
      bus_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      // Flags come from the next-state count so they are valid right after
      // the edge that changes the level.
      txe_n_q   <= (level_d == LEVEL_FULL);
      rxf_n_q   <= (level_d == '0);
      bus_err_q <= bus_err_d;
    end
  end

  // Storage has no reset: stale contents are hidden by the level gate below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {be_i, data_i};
    end
  end

  assign head_word = mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    data_o = '0;
    be_o   = '0;
    rxf_n  = rxf_n_q;
    if (level_q != '0) begin
      data_o = head_word[WIDTH_DATA-1:0];
      be_o   = head_word[WORD_W-1:WIDTH_DATA];
    end
`ifdef FT60X_EMU_PATTERN_EN
    if (pat_mode) begin
      data_o = WIDTH_DATA'(pat_cnt_q);
      be_o   = '1;
      rxf_n  = 1'b0;
    end
`endif
  end

  assign txe_n   = txe_n_q;
  assign level   = level_q;
  assign bus_err = bus_err_q;

endmodule
`default_nettype wire
